// File: rtl/win3x3_gen_int8_pkg.sv
// Shared types and defaults for the 3x3 window generator.
// Pixel width, image size defaults and counter sizing helper.
package win3x3_gen_int8_pkg;

    localparam int DW_DEF    = 8;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win3x3_gen_int8_line_buffer.sv
// One image row of storage, read-before-write at the same address.
// Contents are never reset; the consumer gates output until valid.
module line_buffer_int8
    import win3x3_gen_int8_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = cnt_w(IMG_W_DEF)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/win3x3_gen_int8.sv
// Streaming 3x3 sliding-window generator for signed pixels.
// Emits only full windows; taps register directly onto the outputs.
module win3x3_gen_int8
    import win3x3_gen_int8_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] pix_in,
    output logic [DW-1:0] w1,
    output logic [DW-1:0] w2,
    output logic [DW-1:0] w3,
    output logic [DW-1:0] w4,
    output logic [DW-1:0] w5,
    output logic [DW-1:0] w6,
    output logic [DW-1:0] w7,
    output logic [DW-1:0] w8,
    output logic [DW-1:0] w9,
    output logic          out_valid,
    output logic          frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    // index 0 is the newest column, index 2 the oldest
    logic [2:0][DW-1:0] top_q, top_d;
    logic [2:0][DW-1:0] mid_q, mid_d;
    logic [2:0][DW-1:0] bot_q, bot_d;
    logic out_valid_q, out_valid_d;
    logic frame_done_q, frame_done_d;
    logic [DW-1:0] lb1_rd, lb2_rd;
    logic last_col, last_row;

    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    line_buffer_int8 #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (col_q),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    line_buffer_int8 #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb2 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (col_q),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        top_d        = top_q;
        mid_d        = mid_q;
        bot_d        = bot_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            top_d = {top_q[1:0], lb2_rd};
            mid_d = {mid_q[1:0], lb1_rd};
            bot_d = {bot_q[1:0], pix_in};
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) begin
                row_d = last_row ? '0 : row_q + 1'b1;
            end
            // columns 0 and 1 still hold the previous row's tail
            out_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
            frame_done_d = last_col && last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign w1         = top_q[2];
    assign w2         = top_q[1];
    assign w3         = top_q[0];
    assign w4         = mid_q[2];
    assign w5         = mid_q[1];
    assign w6         = mid_q[0];
    assign w7         = bot_q[2];
    assign w8         = bot_q[1];
    assign w9         = bot_q[0];
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule
